// File: rtl/register_file_scoreboard_if.sv
// ============================================================================
// Module      : register_file_scoreboard_if
// Description : Read, write-back and issue signals of the register file
//               scoreboard, with master (core side) and slave (file) modports.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface register_file_scoreboard_if #(
  parameter int DATA_WIDTH = 32
);
  logic [4:0]            rs_addr;
  logic [4:0]            rt_addr;
  logic [DATA_WIDTH-1:0] rs_data;
  logic [DATA_WIDTH-1:0] rt_data;
  logic                  rs_busy;
  logic                  rt_busy;
  logic                  wr_en;
  logic [4:0]            wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  issue_en;
  logic [4:0]            issue_dst;
  logic [5:0]            busy_count;

  modport master (
    output rs_addr, rt_addr, wr_en, wr_addr, wr_data, issue_en, issue_dst,
    input  rs_data, rt_data, rs_busy, rt_busy, busy_count
  );

  modport slave (
    input  rs_addr, rt_addr, wr_en, wr_addr, wr_data, issue_en, issue_dst,
    output rs_data, rt_data, rs_busy, rt_busy, busy_count
  );
endinterface

`default_nettype wire

// File: rtl/register_file_scoreboard.sv
// ============================================================================
// Module      : register_file_scoreboard
// Description : 32-entry register file with per-register busy bits, write
//               bypass on both read ports and a registered busy counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module register_file_scoreboard #(
  parameter int DATA_WIDTH = 32
) (
  input  wire logic                   clk,
  input  wire logic                   rst_n,
  register_file_scoreboard_if.slave   bus
);

  localparam logic [4:0] c_ZERO_ADDR = 5'd0;

  logic [DATA_WIDTH-1:0] r_regs [32];
  logic [31:0]           r_busy;
  logic [5:0]            r_busy_count;

  logic                  w_wr_hit;
  logic                  w_iss_hit;
  logic [31:0]           w_busy_next;
  logic [5:0]            w_pop;
  logic [DATA_WIDTH-1:0] w_rs_data;
  logic [DATA_WIDTH-1:0] w_rt_data;
  logic                  w_rs_busy;
  logic                  w_rt_busy;

  assign w_wr_hit  = bus.wr_en    && (bus.wr_addr   != c_ZERO_ADDR);
  assign w_iss_hit = bus.issue_en && (bus.issue_dst != c_ZERO_ADDR);

  // Issue is applied after the write so a same-address issue keeps the bit set.
  always_comb begin
    w_busy_next = r_busy;
    if (w_wr_hit) begin
      w_busy_next[bus.wr_addr] = 1'b0;
    end
    if (w_iss_hit) begin
      w_busy_next[bus.issue_dst] = 1'b1;
    end
    w_busy_next[0] = 1'b0;
  end

  always_comb begin
    w_pop = 6'd0;
    for (int i = 0; i < 32; i++) begin
      w_pop = w_pop + {5'd0, r_busy[i]};
    end
  end

  // The counter samples the settled busy vector, so it trails the bits by one edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        r_regs[i] <= '0;
      end
      r_busy       <= '0;
      r_busy_count <= '0;
    end else begin
      if (w_wr_hit) begin
        r_regs[bus.wr_addr] <= bus.wr_data;
      end
      r_busy       <= w_busy_next;
      r_busy_count <= w_pop;
    end
  end

  always_comb begin
    w_rs_data = '0;
    w_rs_busy = 1'b0;
    if (rst_n && (bus.rs_addr != c_ZERO_ADDR)) begin
      if (w_wr_hit && (bus.wr_addr == bus.rs_addr)) begin
        w_rs_data = bus.wr_data;
        w_rs_busy = w_iss_hit && (bus.issue_dst == bus.rs_addr);
      end else begin
        w_rs_data = r_regs[bus.rs_addr];
        w_rs_busy = r_busy[bus.rs_addr];
      end
    end
  end

  always_comb begin
    w_rt_data = '0;
    w_rt_busy = 1'b0;
    if (rst_n && (bus.rt_addr != c_ZERO_ADDR)) begin
      if (w_wr_hit && (bus.wr_addr == bus.rt_addr)) begin
        w_rt_data = bus.wr_data;
        w_rt_busy = w_iss_hit && (bus.issue_dst == bus.rt_addr);
      end else begin
        w_rt_data = r_regs[bus.rt_addr];
        w_rt_busy = r_busy[bus.rt_addr];
      end
    end
  end

  assign bus.rs_data    = w_rs_data;
  assign bus.rt_data    = w_rt_data;
  assign bus.rs_busy    = w_rs_busy;
  assign bus.rt_busy    = w_rt_busy;
  assign bus.busy_count = r_busy_count;

endmodule

`default_nettype wire

// File: tb/tb_register_file_scoreboard.sv
// ============================================================================
// Module      : tb_register_file_scoreboard
// Description : Self-checking bench for register_file_scoreboard with an
//               array-based reference model and randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_register_file_scoreboard;

  localparam int DW = 32;

  logic clk;
  logic rst_n;
  int   n_pass;
  int   n_total;

  logic [DW-1:0] m_mem [32];
  logic [31:0]   m_busy;
  int            m_cnt;

  register_file_scoreboard_if #(.DATA_WIDTH(DW)) bus ();

  register_file_scoreboard #(.DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] exp_data(input logic [4:0] a);
    if (!rst_n || a == 5'd0) return '0;
    if (bus.wr_en && bus.wr_addr == a) return bus.wr_data;
    return m_mem[a];
  endfunction

  function automatic logic exp_busy(input logic [4:0] a);
    if (!rst_n || a == 5'd0) return 1'b0;
    if (bus.wr_en && bus.wr_addr == a) return bus.issue_en && (bus.issue_dst == a);
    return m_busy[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_mem[i] = '0;
    m_busy = '0;
    m_cnt  = 0;
  endtask

  task automatic drive(input logic we, input logic [4:0] wa, input logic [DW-1:0] wd,
                       input logic ie, input logic [4:0] id);
    bus.wr_en     = we;
    bus.wr_addr   = wa;
    bus.wr_data   = wd;
    bus.issue_en  = ie;
    bus.issue_dst = id;
  endtask

  task automatic set_rd(input logic [4:0] a, input logic [4:0] b);
    bus.rs_addr = a;
    bus.rt_addr = b;
  endtask

  // Advance one edge; the model's counter reports the busy population seen before the edge.
  task automatic tick();
    @(posedge clk);
    if (rst_n) begin
      m_cnt = $countones(m_busy);
      if (bus.wr_en && bus.wr_addr != 5'd0) begin
        m_mem[bus.wr_addr]  = bus.wr_data;
        m_busy[bus.wr_addr] = 1'b0;
      end
      if (bus.issue_en && bus.issue_dst != 5'd0) m_busy[bus.issue_dst] = 1'b1;
    end
    #1;
  endtask

  task automatic test_reset();
    logic [4:0] a;
    logic [4:0] b;
    rst_n = 1'b1;
    drive(1'b0, 5'd0, '0, 1'b0, 5'd0);
    set_rd(5'd0, 5'd0);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    n_total++;
    if (bus.busy_count !== 6'd0) $display("FAIL reset_count got=%0d exp=0", bus.busy_count);
    else n_pass++;
    for (int i = 0; i < 32; i++) begin
      a = 5'(i);
      b = 5'(31 - i);
      set_rd(a, b);
      drive(1'b1, a, 32'hCAFE0000 | i, 1'b1, a);
      #1;
      n_total++;
      if (bus.rs_data !== '0 || bus.rs_busy !== 1'b0)
        $display("FAIL reset_rs[%0d] data=%h busy=%b exp data=0 busy=0", i, bus.rs_data, bus.rs_busy);
      else n_pass++;
      n_total++;
      if (bus.rt_data !== '0 || bus.rt_busy !== 1'b0)
        $display("FAIL reset_rt[%0d] data=%h busy=%b exp data=0 busy=0", 31 - i, bus.rt_data, bus.rt_busy);
      else n_pass++;
    end
    drive(1'b0, 5'd0, '0, 1'b0, 5'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_total++;
    if (bus.busy_count !== 6'd0) $display("FAIL reset_release_count got=%0d exp=0", bus.busy_count);
    else n_pass++;
  endtask

  task automatic test_issue_write();
    set_rd(5'd5, 5'd0);
    drive(1'b0, 5'd0, '0, 1'b1, 5'd5);
    #2;
    tick();
    drive(1'b0, 5'd0, '0, 1'b0, 5'd0);
    #2;
    n_total++;
    if (bus.rs_busy !== 1'b1) $display("FAIL iw_busy_after_issue got=%b exp=1", bus.rs_busy);
    else n_pass++;
    drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0);
    #1;
    n_total++;
    if (bus.rs_data !== 32'hDEADBEEF || bus.rs_busy !== 1'b0)
      $display("FAIL iw_bypass data=%h busy=%b exp data=deadbeef busy=0", bus.rs_data, bus.rs_busy);
    else n_pass++;
    tick();
    n_total++;
    if (bus.busy_count !== 6'd1) $display("FAIL iw_count_one got=%0d exp=1", bus.busy_count);
    else n_pass++;
    drive(1'b0, 5'd0, '0, 1'b0, 5'd0);
    tick();
    n_total++;
    if (bus.busy_count !== 6'd0 || bus.rs_data !== 32'hDEADBEEF || bus.rs_busy !== 1'b0)
      $display("FAIL iw_settled count=%0d data=%h busy=%b exp count=0 data=deadbeef busy=0",
               bus.busy_count, bus.rs_data, bus.rs_busy);
    else n_pass++;
  endtask

  task automatic test_same_cycle();
    set_rd(5'd7, 5'd7);
    drive(1'b1, 5'd7, 32'h12345678, 1'b1, 5'd7);
    #2;
    n_total++;
    if (bus.rs_data !== 32'h12345678 || bus.rs_busy !== 1'b1)
      $display("FAIL same_bypass data=%h busy=%b exp data=12345678 busy=1", bus.rs_data, bus.rs_busy);
    else n_pass++;
    tick();
    drive(1'b0, 5'd0, '0, 1'b0, 5'd0);
    #2;
    n_total++;
    if (bus.rt_data !== 32'h12345678 || bus.rt_busy !== 1'b1)
      $display("FAIL same_stored data=%h busy=%b exp data=12345678 busy=1", bus.rt_data, bus.rt_busy);
    else n_pass++;
    tick();
    n_total++;
    if (bus.busy_count !== 6'd1) $display("FAIL same_count got=%0d exp=1", bus.busy_count);
    else n_pass++;
    drive(1'b1, 5'd7, 32'h12345678, 1'b0, 5'd0);
    tick();
    drive(1'b0, 5'd0, '0, 1'b0, 5'd0);
    tick();
  endtask

  task automatic test_reg0();
    set_rd(5'd0, 5'd0);
    drive(1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0);
    #2;
    n_total++;
    if (bus.rs_data !== '0 || bus.rs_busy !== 1'b0)
      $display("FAIL r0_read data=%h busy=%b exp data=0 busy=0", bus.rs_data, bus.rs_busy);
    else n_pass++;
    tick();
    drive(1'b0, 5'd0, '0, 1'b0, 5'd0);
    tick();
    n_total++;
    if (bus.busy_count !== 6'd0 || bus.rt_data !== '0 || bus.rt_busy !== 1'b0)
      $display("FAIL r0_after count=%0d data=%h busy=%b exp count=0 data=0 busy=0",
               bus.busy_count, bus.rt_data, bus.rt_busy);
    else n_pass++;
  endtask

  task automatic test_fill();
    for (int i = 1; i < 32; i++) begin
      drive(1'b0, 5'd0, '0, 1'b1, 5'(i));
      tick();
    end
    drive(1'b0, 5'd0, '0, 1'b0, 5'd0);
    tick();
    n_total++;
    if (bus.busy_count !== 6'd31) $display("FAIL fill_31 got=%0d exp=31", bus.busy_count);
    else n_pass++;
    drive(1'b0, 5'd0, '0, 1'b1, 5'd3);
    tick();
    drive(1'b0, 5'd0, '0, 1'b0, 5'd0);
    tick();
    n_total++;
    if (bus.busy_count !== 6'd31) $display("FAIL fill_reissue got=%0d exp=31", bus.busy_count);
    else n_pass++;
    drive(1'b1, 5'd3, 32'h00000333, 1'b0, 5'd0);
    tick();
    drive(1'b0, 5'd0, '0, 1'b0, 5'd0);
    tick();
    n_total++;
    if (bus.busy_count !== 6'd30) $display("FAIL fill_write3 got=%0d exp=30", bus.busy_count);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [4:0] wa;
    logic [4:0] id;
    for (int c = 0; c < 300; c++) begin
      wa = 5'($urandom_range(0, 31));
      id = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      drive(1'($urandom_range(0, 1)), wa, $urandom, 1'($urandom_range(0, 1)), id);
      set_rd(($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31)),
             ($urandom_range(0, 2) == 0) ? id : 5'($urandom_range(0, 31)));
      #2;
      n_total++;
      if (bus.rs_data !== exp_data(bus.rs_addr) || bus.rs_busy !== exp_busy(bus.rs_addr))
        $display("FAIL rand_rs cyc=%0d addr=%0d data=%h busy=%b exp data=%h busy=%b", c, bus.rs_addr,
                 bus.rs_data, bus.rs_busy, exp_data(bus.rs_addr), exp_busy(bus.rs_addr));
      else n_pass++;
      n_total++;
      if (bus.rt_data !== exp_data(bus.rt_addr) || bus.rt_busy !== exp_busy(bus.rt_addr))
        $display("FAIL rand_rt cyc=%0d addr=%0d data=%h busy=%b exp data=%h busy=%b", c, bus.rt_addr,
                 bus.rt_data, bus.rt_busy, exp_data(bus.rt_addr), exp_busy(bus.rt_addr));
      else n_pass++;
      tick();
      n_total++;
      if (bus.busy_count !== 6'(m_cnt))
        $display("FAIL rand_count cyc=%0d got=%0d exp=%0d", c, bus.busy_count, m_cnt);
      else n_pass++;
    end
  endtask

  task automatic test_async_reset();
    set_rd(5'd0, 5'd9);
    drive(1'b1, 5'd9, 32'hA5A5A5A5, 1'b1, 5'd9);
    tick();
    drive(1'b0, 5'd0, '0, 1'b0, 5'd0);
    tick();
    tick();
    #2;
    n_total++;
    if (bus.rt_data !== 32'hA5A5A5A5 || bus.rt_busy !== 1'b1 || bus.busy_count !== 6'(m_cnt))
      $display("FAIL ar_before data=%h busy=%b count=%0d exp data=a5a5a5a5 busy=1 count=%0d",
               bus.rt_data, bus.rt_busy, bus.busy_count, m_cnt);
    else n_pass++;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_total++;
    if (bus.busy_count !== 6'd0 || bus.rt_data !== '0 || bus.rt_busy !== 1'b0)
      $display("FAIL ar_immediate count=%0d data=%h busy=%b exp all 0",
               bus.busy_count, bus.rt_data, bus.rt_busy);
    else n_pass++;
    drive(1'b1, 5'd9, 32'h11111111, 1'b1, 5'd9);
    tick();
    drive(1'b0, 5'd0, '0, 1'b0, 5'd0);
    rst_n = 1'b1;
    #2;
    n_total++;
    if (bus.rt_data !== '0 || bus.rt_busy !== 1'b0)
      $display("FAIL ar_discard data=%h busy=%b exp data=0 busy=0", bus.rt_data, bus.rt_busy);
    else n_pass++;
    drive(1'b1, 5'd9, 32'h0000BEEF, 1'b0, 5'd0);
    tick();
    drive(1'b0, 5'd0, '0, 1'b0, 5'd0);
    #2;
    n_total++;
    if (bus.rt_data !== 32'h0000BEEF || bus.busy_count !== 6'd0)
      $display("FAIL ar_first_write data=%h count=%0d exp data=0000beef count=0",
               bus.rt_data, bus.busy_count);
    else n_pass++;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    test_reset();
    test_issue_write();
    test_same_cycle();
    test_reg0();
    test_fill();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/register_file_scoreboard.md
REGISTER_FILE_SCOREBOARD -- requirements
Module: register_file_scoreboard

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, register data width; the address width is fixed at 5 bits (32 registers).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have ports rs_addr, rt_addr  input  5  read port source addresses.
REQ-005 SHALL have ports rs_data, rt_data  output  DATA_WIDTH  read port data, combinational.
REQ-006 SHALL have ports rs_busy, rt_busy  output  1  source register has a pending producer, combinational.
REQ-007 SHALL have port wr_en  input  1  write-back strobe.
REQ-008 SHALL have port wr_addr  input  5  write-back destination, driven by the 5-bit destination select mux.
REQ-009 SHALL have port wr_data  input  DATA_WIDTH  write-back data.
REQ-010 SHALL have port issue_en  input  1  instruction issued with a destination.
REQ-011 SHALL have port issue_dst  input  5  destination of the issued instruction.
REQ-012 SHALL have port busy_count  output  6  registered number of set busy bits (0..31).

Function
REQ-013 SHALL hold 32 data registers and 32 busy bits; register 0 reads 0 and is never busy.
REQ-014 SHALL ignore writes and issues addressed to register 0, with no state change.
REQ-015 SHALL, on a rising edge with wr_en=1 and wr_addr!=0, store wr_data into register wr_addr and clear its busy bit.
REQ-016 SHALL, on a rising edge with issue_en=1 and issue_dst!=0, set busy bit issue_dst.
REQ-017 SHALL, when issue and write target the same nonzero address in one cycle, store wr_data and leave the busy bit SET (the newer producer wins).
REQ-018 SHALL treat an issue to an already-busy register as a busy-bit no-op; busy_count is unchanged.
REQ-019 SHALL treat a write to a non-busy register as a data write only; busy_count is unchanged.
REQ-020 SHALL bypass writes to reads: when wr_en=1, wr_addr!=0 and wr_addr==rs_addr, rs_data SHALL equal wr_data in the same cycle; rt_data follows the same rule.
REQ-021 SHALL, in the REQ-020 case, drive rs_busy/rt_busy to 0 unless issue_en=1 with issue_dst equal to that address in the same cycle.
REQ-022 SHALL otherwise drive rs_busy/rt_busy directly from the stored busy bit of the addressed register.
REQ-023 SHALL update busy_count one cycle after the busy-bit change, equal to the popcount of busy bits after the edge, using a 6-bit result with no wrap.
REQ-024 SHALL handle a simultaneous issue and write to different nonzero registers (busy set on one, cleared on the other) with a net busy_count change computed exactly (-1, 0 or +1).

Reset
REQ-025 SHALL, while rst_n=0, clear all data registers to 0, all busy bits to 0 and busy_count to 0, independent of clk.
REQ-026 SHALL, when reset is asserted mid-operation, discard any same-edge write or issue; the first update after reset occurs on the first rising edge with rst_n=1.
REQ-027 SHALL drive rs_data=rt_data=0 and rs_busy=rt_busy=0 during reset for any addresses.

Verification
REQ-028 Reset then read all 32 addresses on both ports -> data 0, busy 0, busy_count 0.
REQ-029 Issue dst 5, next cycle write r5=0xDEADBEEF, rs_addr=5 throughout -> rs_busy 1 for one cycle; during the write cycle rs_data=0xDEADBEEF and rs_busy=0; busy_count goes 1 then 0.
REQ-030 Same cycle issue_dst=7 and wr_addr=7 (data 0x12345678) -> r7=0x12345678, busy bit set, busy_count 1.
REQ-031 Issue and write to register 0 (data 0xFFFFFFFF) -> rs_addr=0 gives data 0 and busy 0, busy_count 0.
REQ-032 Issue r1..r31 on 31 consecutive cycles -> busy_count reaches 31; issuing r3 again leaves 31; writing r3 gives 30.
REQ-033 With r9 busy, assert rst_n=0 between clock edges -> busy_count and rt_data (rt_addr=9) drop to 0 immediately, without waiting for a clock edge.
